// File: rtl/pn_seq_checker_pkg.sv
// Shared definitions for the 3-stage PN checker: FSM state encoding and the
// generator feedback tap (s0 = s1 ^ s3), kept identical to the transmit side.
package pn_seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } pn_state_t;

    function automatic logic pn_tap(input logic s1, input logic s3);
        return s1 ^ s3;
    endfunction

endpackage

// File: rtl/pn_seq_checker_lfsr3_step.sv
// Combinational one-step advance of the 3-bit PN model, packed as {m1,m2,m3}.
module pn_lfsr3_step
    import pn_seq_checker_pkg::*;
(
    input  logic [2:0] cur,
    output logic [2:0] nxt
);

    assign nxt = {pn_tap(cur[2], cur[0]), cur[2], cur[1]};

endmodule

// File: rtl/pn_seq_checker.sv
// Receive-side PN sequence checker: self-seeds from two samples, verifies, locks, flags errors.
// Optional saturating error counter (err_clr/err_cnt) enabled by defining PN_CHK_ERRCNT_EN.
module pn_seq_checker
    import pn_seq_checker_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [1:0]       rand_in,
`ifdef PN_CHK_ERRCNT_EN
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             locked,
    output logic             err
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(ERR_THRESH + 1);

    pn_state_t          state;
    logic               prev_vld;
    logic [1:0]         prev_sym;
    logic [2:0]         model;
    logic [2:0]         model_nxt;
    logic [2:0]         seed;
    logic [2:0]         seed_nxt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic [1:0]         exp_sym;
    logic               seed_ok;
    logic               sym_match;
    logic               err_set;

    // Model state at the current sample reconstructed from {p, c}; s2 of p reappears as s3 of c.
    assign seed      = {rand_in[0] ^ prev_sym[1], rand_in[0], rand_in[1]};
    assign seed_ok   = prev_vld && (rand_in[1] == prev_sym[0]) && (seed != 3'b000);
    assign exp_sym   = {model[0], model[1]};
    assign sym_match = (rand_in == exp_sym);
    assign err_set   = in_vld && (state == LOCKED) && !sym_match;

    pn_lfsr3_step u_seed_step  (.cur(seed),  .nxt(seed_nxt));
    pn_lfsr3_step u_model_step (.cur(model), .nxt(model_nxt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            prev_vld  <= 1'b0;
            prev_sym  <= '0;
            model     <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (in_vld) begin
                unique case (state)
                    HUNT: begin
                        if (seed_ok) begin
                            state     <= VERIFY;
                            model     <= seed_nxt;
                            match_cnt <= '0;
                        end else begin
                            prev_sym <= rand_in;
                            prev_vld <= 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (sym_match) begin
                            model <= model_nxt;
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            state    <= HUNT;
                            prev_sym <= rand_in;
                            prev_vld <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Model free-runs through errors so isolated hits do not cost a resync.
                        model <= model_nxt;
                        if (sym_match) begin
                            miss_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                            if (miss_cnt == MISS_W'(ERR_THRESH - 1)) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                prev_vld <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef PN_CHK_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_set && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_err_set;
    assign unused_err_set = err_set;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// Directed bench for pn_seq_checker: lock latency, stuck input, single/burst errors, gapped valid, reset.
module tb_pn_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic [1:0] rand_in;
    logic       locked;
    logic       err;
`ifdef PN_CHK_ERRCNT_EN
    logic        err_clr;
    logic [15:0] err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int gi     = 0;
    logic [1:0] gen_seq [7] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2};

    always #5 clk = ~clk;

    pn_seq_checker #(.LOCK_CNT(4), .ERR_THRESH(3), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .rand_in (rand_in),
`ifdef PN_CHK_ERRCNT_EN
        .err_clr (err_clr),
        .err_cnt (err_cnt),
`endif
        .locked  (locked),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic send(input logic v, input logic [1:0] s);
        @(negedge clk);
        in_vld  = v;
        rand_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean();
        send(1'b1, gen_seq[gi]);
        gi = (gi + 1) % 7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        rand_in = 2'd0;
`ifdef PN_CHK_ERRCNT_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gi    = 0;
    endtask

    task automatic lock_up(input string tag);
        for (int i = 1; i <= 6; i++) begin
            send_clean();
            chk(tag, {31'd0, locked}, (i == 6) ? 32'd1 : 32'd0);
            chk("lock_err", {31'd0, err}, 32'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        rand_in = 2'd0;
`ifdef PN_CHK_ERRCNT_EN
        err_clr = 1'b0;
`endif
        #12;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
`ifdef PN_CHK_ERRCNT_EN
        chk("rst_errcnt", {16'd0, err_cnt}, 32'd0);
`endif
        do_reset();

        // clean stream: lock after the sixth sample, no errors afterwards
        lock_up("clean_lock");
        for (int i = 0; i < 94; i++) begin
            send_clean();
            chk("clean_err", {31'd0, err}, 32'd0);
            chk("clean_locked", {31'd0, locked}, 32'd1);
        end

        // single corruption 11 -> 01
        while (gen_seq[gi] != 2'd3) send_clean();
        send(1'b1, 2'd1);
        gi = (gi + 1) % 7;
        chk("single_err", {31'd0, err}, 32'd1);
        chk("single_locked", {31'd0, locked}, 32'd1);
`ifdef PN_CHK_ERRCNT_EN
        chk("single_errcnt", {16'd0, err_cnt}, 32'd1);
`endif
        send_clean();
        chk("single_err_clear", {31'd0, err}, 32'd0);
        chk("single_locked2", {31'd0, locked}, 32'd1);

        // three consecutive corruptions drop lock
        for (int i = 1; i <= 3; i++) begin
`ifdef PN_CHK_ERRCNT_EN
            err_clr = (i == 3);
`endif
            send(1'b1, gen_seq[gi] ^ 2'b01);
            gi = (gi + 1) % 7;
            chk("burst_err", {31'd0, err}, 32'd1);
            chk("burst_locked", {31'd0, locked}, (i == 3) ? 32'd0 : 32'd1);
`ifdef PN_CHK_ERRCNT_EN
            chk("burst_errcnt", {16'd0, err_cnt}, (i == 3) ? 32'd0 : 32'(i + 1));
`endif
        end
`ifdef PN_CHK_ERRCNT_EN
        err_clr = 1'b0;
`endif
        lock_up("relock");

        // stuck-at 00 never seeds
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 2'd0);
            chk("stuck_locked", {31'd0, locked}, 32'd0);
            chk("stuck_err", {31'd0, err}, 32'd0);
        end

        // gapped valid: lock point counted in valid samples only
        do_reset();
        begin
            int vcount = 0;
            for (int cyc = 0; cyc < 200 && vcount < 12; cyc++) begin
                if ($urandom_range(0, 1) == 1) begin
                    send_clean();
                    vcount++;
                end else begin
                    send(1'b0, 2'($urandom_range(0, 3)));
                end
                chk("gap_locked", {31'd0, locked}, (vcount >= 6) ? 32'd1 : 32'd0);
                chk("gap_err", {31'd0, err}, 32'd0);
            end
            chk("gap_budget", vcount, 32'd12);
        end

        // async reset while an err pulse is on the output
        do_reset();
        lock_up("pre_rst_lock");
        send(1'b1, gen_seq[gi] ^ 2'b10);
        gi = (gi + 1) % 7;
        chk("pre_rst_err", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", {31'd0, locked}, 32'd0);
        chk("async_rst_err", {31'd0, err}, 32'd0);
`ifdef PN_CHK_ERRCNT_EN
        chk("async_rst_errcnt", {16'd0, err_cnt}, 32'd0);
`endif
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
